// File: rtl/burst_ram_arbiter.sv
// Round-robin burst arbiter in front of one PSRAM burst-RAM controller port.
// Grants whole bursts, routes beats, enforces command spacing and read timeout.
module burst_ram_arbiter #(
  parameter int CHANNELS     = 2,
  parameter int ADDR_WIDTH   = 21,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_BEATS  = 4,
  parameter int CMD_GAP      = 14,
  parameter int READ_TIMEOUT = 255,
  localparam int MASK_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_calib,
  input  logic [CHANNELS-1:0]            c_req,
  input  logic [CHANNELS-1:0]            c_cmd,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] c_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0] c_wr_data,
  input  logic [CHANNELS*MASK_WIDTH-1:0] c_data_mask,
  output logic [CHANNELS-1:0]            c_ack,
  output logic [DATA_WIDTH-1:0]          c_rd_data,
  output logic [CHANNELS-1:0]            c_rd_data_valid,
  output logic                           br_cmd,
  output logic                           br_cmd_en,
  output logic [ADDR_WIDTH-1:0]          br_addr,
  output logic [DATA_WIDTH-1:0]          br_wr_data,
  output logic [MASK_WIDTH-1:0]          br_data_mask,
  input  logic [DATA_WIDTH-1:0]          br_rd_data,
  input  logic                           br_rd_data_valid,
  output logic                           timeout_err
);

  localparam int MAX_AB = (BURST_BEATS > CMD_GAP) ? BURST_BEATS : CMD_GAP;
  localparam int MAXC   = (MAX_AB > READ_TIMEOUT) ? MAX_AB : READ_TIMEOUT;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int GW     = $clog2(CHANNELS);

  localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_BEATS - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(READ_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  =
    (CMD_GAP == 0) ? '0 : CW'(CMD_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WBEATS, RWAIT, GAP
  } state_t;

  localparam state_t POST = (CMD_GAP == 0) ? IDLE : GAP;

  state_t                state, state_nx;
  logic [GW-1:0]         grant, last, sel;
  logic                  cmd_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         cnt, timer;
  logic                  any_req;
  logic                  rd_done, rd_tmo;
  logic                  cnt_inc, wr_phase;

  assign c_rd_data = br_rd_data;

  // Scan upward from the channel after the last one served.
  always_comb begin
    int j;
    j       = 0;
    sel     = '0;
    any_req = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      j = (int'(last) + i) % CHANNELS;
      if (!any_req && c_req[j]) begin
        any_req = 1'b1;
        sel     = GW'(j);
      end
    end
  end

  assign rd_done = (state == RWAIT) && br_rd_data_valid &&
                   (cnt == BEAT_LAST);
  assign rd_tmo  = (state == RWAIT) && !rd_done &&
                   (timer == TMO_LAST);
  assign cnt_inc = (state == WBEATS) || (state == GAP) ||
                   ((state == RWAIT) && br_rd_data_valid);
  assign wr_phase = ((state == ISSUE) && cmd_q) ||
                    (state == WBEATS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (init_calib && any_req) state_nx = ISSUE;
      ISSUE:
        if (!cmd_q)                state_nx = RWAIT;
        else if (BURST_BEATS == 1) state_nx = POST;
        else                       state_nx = WBEATS;
      WBEATS:
        if (cnt == BEAT_LAST) state_nx = POST;
      RWAIT:
        if (rd_done || rd_tmo) state_nx = POST;
      GAP:
        if (cnt == GAP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Timer value equals cycles elapsed since the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      last        <= GW'(CHANNELS - 1);
      cmd_q       <= 1'b0;
      addr_q      <= '0;
      cnt         <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_nx == ISSUE)) begin
        grant  <= sel;
        cmd_q  <= c_cmd[sel];
        addr_q <= c_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (state == ISSUE) last <= grant;
      if (state != state_nx)
        cnt <= (state_nx == WBEATS) ? CW'(1) : '0;
      else if (cnt_inc)
        cnt <= cnt + CW'(1);
      if (state == ISSUE)      timer <= CW'(1);
      else if (state == RWAIT) timer <= timer + CW'(1);
      if (rd_tmo) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    c_ack           = '0;
    c_rd_data_valid = '0;
    br_cmd_en       = 1'b0;
    br_cmd          = 1'b0;
    br_addr         = '0;
    br_wr_data      = '0;
    br_data_mask    = '1;
    unique case (1'b1)
      (state == ISSUE): begin
        c_ack[grant] = 1'b1;
        br_cmd_en    = 1'b1;
        br_cmd       = cmd_q;
        br_addr      = addr_q;
      end
      (state == RWAIT):
        c_rd_data_valid[grant] = br_rd_data_valid;
      default: ;
    endcase
    if (wr_phase) begin
      br_wr_data   =
        c_wr_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      br_data_mask =
        c_data_mask[int'(grant)*MASK_WIDTH +: MASK_WIDTH];
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: grant order, beat routing,
// command spacing, read routing, timeout and mid-burst reset.
module tb_burst_ram_arbiter;

  localparam int CH = 2;
  localparam int AW = 21;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic             clk;
  logic             rst_n;
  logic             init_calib;
  logic [CH-1:0]    c_req, c_cmd;
  logic [CH*AW-1:0] c_addr;
  logic [CH*DW-1:0] c_wr_data;
  logic [CH*MW-1:0] c_data_mask;
  logic [CH-1:0]    c_ack;
  logic [DW-1:0]    c_rd_data;
  logic [CH-1:0]    c_rd_data_valid;
  logic             br_cmd, br_cmd_en;
  logic [AW-1:0]    br_addr;
  logic [DW-1:0]    br_wr_data;
  logic [MW-1:0]    br_data_mask;
  logic [DW-1:0]    br_rd_data;
  logic             br_rd_data_valid;
  logic             timeout_err;

  burst_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_calib(init_calib),
    .c_req(c_req), .c_cmd(c_cmd), .c_addr(c_addr),
    .c_wr_data(c_wr_data), .c_data_mask(c_data_mask),
    .c_ack(c_ack), .c_rd_data(c_rd_data),
    .c_rd_data_valid(c_rd_data_valid),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
    .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int ack_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst_n) ack_cnt <= ack_cnt + $countones(c_ack);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cmd(input int limit, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < limit) begin
      step();
      ok = br_cmd_en;
      i++;
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  exp_ack;
    logic [20:0] exp_addr;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int t0, a0, v0, v1, bad;

    tbl[0] = '{2'b11, 2'b01, 21'h00AAA};
    tbl[1] = '{2'b11, 2'b10, 21'h00BBB};
    tbl[2] = '{2'b11, 2'b01, 21'h00AAA};
    tbl[3] = '{2'b11, 2'b10, 21'h00BBB};
    tbl[4] = '{2'b11, 2'b01, 21'h00AAA};
    tbl[5] = '{2'b11, 2'b10, 21'h00BBB};
    tbl[6] = '{2'b01, 2'b01, 21'h00AAA};
    tbl[7] = '{2'b01, 2'b01, 21'h00AAA};
    tbl[8] = '{2'b10, 2'b10, 21'h00BBB};
    tbl[9] = '{2'b10, 2'b10, 21'h00BBB};

    rst_n = 1'b0;
    init_calib = 1'b0;
    c_req = '0;
    c_cmd = 2'b11;
    c_addr = '0;
    c_wr_data = '0;
    c_data_mask = '0;
    br_rd_data = '0;
    br_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_en", br_cmd_en, 0);
    chk("rst_ack", c_ack, 0);
    chk("rst_addr", br_addr, 0);
    chk("rst_wdata", br_wr_data, 0);
    chk("rst_mask", br_data_mask, 8'hFF);
    chk("rst_err", timeout_err, 0);

    // Held off until calibration.
    c_addr[0*AW +: AW] = 21'h00100;
    c_addr[1*AW +: AW] = 21'h01234;
    c_req = 2'b11;
    bad = 0;
    repeat (50) begin
      step();
      if (br_cmd_en || c_ack != 0 || c_rd_data_valid != 0) bad++;
    end
    chk("calib_hold", bad, 0);
    @(negedge clk);
    init_calib = 1'b1;
    step();
    chk("first_cmd_en", br_cmd_en, 1);
    chk("first_ack", c_ack, 2'b01);
    chk("first_addr", br_addr, 21'h00100);
    t0 = cyc;
    c_req = 2'b10;
    c_wr_data[1*DW +: DW] = 64'hA0;
    c_data_mask[1*MW +: MW] = 8'h0F;

    // Ch1 write burst.
    wait_cmd(40, ok);
    chk("wr_wait", ok, 1);
    chk("wr_spacing", cyc - t0, 19);
    chk("wr_ack", c_ack, 2'b10);
    chk("wr_cmd", br_cmd, 1);
    chk("wr_addr", br_addr, 21'h01234);
    chk("wr_beat0", br_wr_data, 64'hA0);
    chk("wr_mask", br_data_mask, 8'h0F);
    c_req = 2'b00;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      c_wr_data[1*DW +: DW] = 64'hA0 + 64'(k);
      #1;
      chk("wr_beat", br_wr_data, 64'hA0 + 64'(k));
      chk("wr_beat_cmd_en", br_cmd_en, 0);
    end
    step();
    chk("gap_wdata", br_wr_data, 0);
    chk("gap_mask", br_data_mask, 8'hFF);

    // Round-robin table.
    c_addr[0*AW +: AW] = 21'h00AAA;
    c_addr[1*AW +: AW] = 21'h00BBB;
    c_cmd = 2'b11;
    a0 = ack_cnt;
    for (int r = 0; r < 10; r++) begin
      c_req = tbl[r].req;
      wait_cmd(40, ok);
      chk($sformatf("rr_wait%0d", r), ok, 1);
      chk($sformatf("rr_ack%0d", r), c_ack, tbl[r].exp_ack);
      chk($sformatf("rr_addr%0d", r), br_addr, tbl[r].exp_addr);
    end
    c_req = 2'b00;
    repeat (25) step();
    chk("rr_ack_count", ack_cnt - a0, 10);

    // Ch0 read, beats 12 cycles after issue, stray beat in GAP.
    c_cmd = 2'b00;
    c_addr[0*AW +: AW] = 21'h00321;
    c_req = 2'b01;
    wait_cmd(10, ok);
    chk("rd_wait", ok, 1);
    chk("rd_ack", c_ack, 2'b01);
    chk("rd_cmd", br_cmd, 0);
    chk("rd_addr", br_addr, 21'h00321);
    c_req = 2'b00;
    v0 = 0;
    v1 = 0;
    for (int off = 1; off <= 30; off++) begin
      @(negedge clk);
      br_rd_data_valid = (off >= 12 && off <= 16);
      br_rd_data = 64'hD0 + 64'(off);
      #1;
      v0 += int'(c_rd_data_valid[0]);
      v1 += int'(c_rd_data_valid[1]);
      if (off == 12) chk("rd_first_valid", c_rd_data_valid, 2'b01);
      if (off == 13) chk("rd_data", c_rd_data, 64'hDD);
      if (off == 16) chk("rd_stray", c_rd_data_valid, 2'b00);
    end
    br_rd_data_valid = 1'b0;
    chk("rd_ch0_beats", v0, 4);
    chk("rd_ch1_beats", v1, 0);
    chk("rd_no_err", timeout_err, 0);

    // Ch0 read with no reply, ch1 write waiting.
    c_cmd = 2'b10;
    c_req = 2'b01;
    wait_cmd(10, ok);
    chk("tmo_wait", ok, 1);
    chk("tmo_ack", c_ack, 2'b01);
    t0 = cyc;
    c_req = 2'b10;
    bad = 0;
    for (int off = 1; off <= 255; off++) begin
      step();
      if (br_cmd_en) bad++;
      if (off == 254) chk("tmo_not_yet", timeout_err, 0);
      if (off == 255) chk("tmo_set", timeout_err, 1);
    end
    chk("tmo_no_cmd", bad, 0);
    wait_cmd(40, ok);
    chk("tmo_next_wait", ok, 1);
    chk("tmo_next_at", cyc - t0, 270);
    chk("tmo_next_ack", c_ack, 2'b10);
    c_req = 2'b00;
    repeat (20) step();
    chk("tmo_sticky", timeout_err, 1);

    // Reset in the middle of a ch1 write.
    c_cmd = 2'b11;
    c_req = 2'b10;
    c_wr_data[1*DW +: DW] = 64'h55;
    wait_cmd(10, ok);
    chk("mrst_wait", ok, 1);
    chk("mrst_ack", c_ack, 2'b10);
    @(negedge clk);
    c_wr_data[1*DW +: DW] = 64'h56;
    @(negedge clk);
    c_wr_data[1*DW +: DW] = 64'h57;
    #1;
    chk("mrst_beat2", br_wr_data, 64'h57);
    c_req = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("mrst_cmd_en", br_cmd_en, 0);
    chk("mrst_ack0", c_ack, 0);
    chk("mrst_wdata", br_wr_data, 0);
    chk("mrst_err", timeout_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cmd(5, ok);
    chk("mrst_rewait", ok, 1);
    chk("mrst_ch0_first", c_ack, 2'b01);
    c_req = 2'b00;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
